memshare_rqstaddr_gen: RTL

- Read-address generator for the message-passing buffer during SCU.memShare().
- Loads the DRC base address at SCU start, then issues RQST_NUM read requests over a valid/ready handshake.
- Advances the address by the per-request increment operand from the rqstAddr operand controller, modulo buffer depth.
- Sits between the operand controller (upstream) and the message-passing buffer read port / arbiter (downstream).

---
 rtl/memshare_rqstaddr_gen.sv | 134 +++++++++++++
 1 files changed

// File: rtl/memshare_rqstaddr_gen.sv
// Read-address generator for the message-passing buffer during SCU.memShare(); latency: start -> first request 1 cycle.
// Backpressure: request held stable until rd_ready_i; optional MEMSHARE_RQSTADDR_RESTART_EN restarts a period on an overlapping start.
module memshare_rqstaddr_gen #(
    parameter int BUFF_DEPTH    = 48,
    parameter int ADDR_WIDTH    = 6,
    parameter int OPERAND_WIDTH = 3,
    parameter int RQST_NUM      = 8,
    parameter int CNT_WIDTH     = $clog2(RQST_NUM + 1)
) (
    input  logic                     sys_clk,
    input  logic                     rstn,
    input  logic                     scu_begin_i,
    input  logic [ADDR_WIDTH-1:0]    base_addr_i,
    input  logic [OPERAND_WIDTH-1:0] increment_operand_i,
    input  logic                     rd_ready_i,
    output logic                     rd_valid_o,
    output logic [ADDR_WIDTH-1:0]    rd_addr_o,
    output logic [CNT_WIDTH-1:0]     rqst_cnt_o,
    output logic                     done_o,
    output logic                     overlap_err_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef logic [ADDR_WIDTH:0] sum_t;

    localparam sum_t                 DEPTH_W  = sum_t'(BUFF_DEPTH);
    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(RQST_NUM - 1);
    localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(RQST_NUM);

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_nxt;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_nxt;
    logic                    valid_q, valid_nxt;
    logic                    ovl_q, ovl_nxt;
    logic                    handshake;
    logic                    start_load;
    sum_t                    sum;
    sum_t                    sum_wrap;
    logic [ADDR_WIDTH-1:0]   addr_adv;

    // One conditional subtract suffices because the operand is always below the depth.
    always_comb begin
        sum      = sum_t'(addr_q) + sum_t'(increment_operand_i);
        sum_wrap = (sum >= DEPTH_W) ? (sum - DEPTH_W) : sum;
        addr_adv = sum_wrap[ADDR_WIDTH-1:0];
    end

    assign handshake = valid_q & rd_ready_i;

    always_comb begin
        state_nxt  = state;
        addr_nxt   = addr_q;
        cnt_nxt    = cnt_q;
        valid_nxt  = valid_q;
        ovl_nxt    = ovl_q;
        start_load = 1'b0;

        case (state)
            IDLE, DONE: begin
                state_nxt = IDLE;
                if (scu_begin_i) begin
                    start_load = 1'b1;
                    addr_nxt   = base_addr_i;
                    cnt_nxt    = '0;
                    valid_nxt  = 1'b1;
                    state_nxt  = ISSUE;
                end
            end

            ISSUE: begin
`ifdef MEMSHARE_RQSTADDR_RESTART_EN
                if (scu_begin_i) begin
                    // Restart wins over any handshake in the same cycle.
                    start_load = 1'b1;
                    addr_nxt   = base_addr_i;
                    cnt_nxt    = '0;
                    valid_nxt  = 1'b1;
                end else if (handshake) begin
`else
                if (scu_begin_i) begin
                    ovl_nxt = 1'b1;
                end
                if (handshake) begin
`endif
                    if (cnt_q == LAST_CNT) begin
                        cnt_nxt   = FULL_CNT;
                        valid_nxt = 1'b0;
                        state_nxt = DONE;
                    end else begin
                        cnt_nxt  = cnt_q + CNT_WIDTH'(1);
                        addr_nxt = addr_adv;
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
                valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            state   <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            ovl_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            addr_q  <= addr_nxt;
            cnt_q   <= cnt_nxt;
            valid_q <= valid_nxt;
            ovl_q   <= ovl_nxt;
        end
    end

    assign rd_valid_o    = valid_q;
    assign rd_addr_o     = addr_q;
    assign rqst_cnt_o    = cnt_q;
    assign done_o        = (state == DONE);
    assign overlap_err_o = ovl_q;

    // Out-of-range base is a caller error; flag it where it is loaded.
    a_base_in_range: assert property (@(posedge sys_clk) disable iff (!rstn)
        start_load |-> (sum_t'(base_addr_i) < DEPTH_W));

endmodule
